serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_if.sv | 30 +++
 rtl/serial_adder_fa_cell.sv | 16 +
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Holds the FSM state encoding, the default operand width and the counter-width helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-index counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operation request / result bundle for serial_adder.
// master = requester, slave = the adder.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder; the only arithmetic element of the serial datapath.
module fa_cell (
    input  logic x1,
    input  logic x2,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = x1 ^ x2;
    assign s    = p ^ cin;
    assign cout = (x1 & x2) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through one fa_cell.
// Subtraction is a + ~b with the carry seeded by cin ^ 1, so cout reads as not-borrow.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting; start latches operands and mode
//   RUN   | one bit per edge, bit index = count; leaves after bit WIDTH-1
//   DONE  | done pulse for one cycle, result stable; always back to IDLE
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_adder_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;

    logic             busy;
    logic             done;
    logic             accept;
    logic             step;
    logic             last_bit;
    logic             fa_s;
    logic             fa_co;

    assign last_bit = (count == CW'(WIDTH - 1));

    fa_cell u_fa (
        .x1   (a_r[count]),
        .x2   (b_r[count]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        accept = 1'b0;
        step   = 1'b0;
        case (state)
            IDLE: accept = bus.start;
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            count  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            a_r   <= bus.a;
            b_r   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.cin ^ bus.sub;
            count <= '0;
        end else if (step) begin
            sum_r[count] <= fa_s;
            carry        <= fa_co;
            count        <= count + 1'b1;
            // carry still holds the carry into the MSB on the last bit
            if (last_bit) begin
                cout_r <= fa_co;
                ovf_r  <= carry ^ fa_co;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 vector table plus multi-cycle corner
// sequences, and a WIDTH=1 instance run back-to-back over the full-adder truth table.
module tb_serial_adder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    serial_adder_if #(.WIDTH(8)) b8 ();
    serial_adder_if #(.WIDTH(1)) b1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one WIDTH=8 operation and return edges from accept to first done.
    task automatic op8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, output int lat);
        @(negedge clk);
        b8.start = 1'b1;
        b8.sub   = s;
        b8.a     = av;
        b8.b     = bv;
        b8.cin   = ci;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        lat = 0;
        while (!b8.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n_done;
        int first_done;
        int last_done;
        logic [7:0] sum_at_done;
        logic [1:0] exp2;
        logic       wa, wb, wc;

        checks = 0;
        errors = 0;
        cyc    = 0;
        b8.start = 1'b0; b8.sub = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
        b1.start = 1'b0; b1.sub = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0;

        vecs[0] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFD, 1'b0, 1'b0};

        // reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(b8.busy), 64'd0);
        check("rst_done", 64'(b8.done), 64'd0);
        check("rst_sum",  64'(b8.sum),  64'd0);
        check("rst_cout", 64'(b8.cout), 64'd0);
        check("rst_ovf",  64'(b8.ovf),  64'd0);
        check("rst_w1_busy", 64'(b1.busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // vector table
        for (int i = 0; i < 10; i++) begin
            op8(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd8);
            check($sformatf("v%0d_sum", i),  64'(b8.sum),  64'(vecs[i].sum));
            check($sformatf("v%0d_cout", i), 64'(b8.cout), 64'(vecs[i].cout));
            check($sformatf("v%0d_ovf", i),  64'(b8.ovf),  64'(vecs[i].ovf));
            check($sformatf("v%0d_busy_done", i), 64'(b8.busy), 64'd1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_width", i), 64'(b8.done), 64'd0);
            check($sformatf("v%0d_idle", i), 64'(b8.busy), 64'd0);
        end

        // result held while idle
        repeat (5) @(posedge clk);
        #1;
        check("hold_sum",  64'(b8.sum),  64'(vecs[9].sum));
        check("hold_cout", 64'(b8.cout), 64'(vecs[9].cout));

        // start with new operands mid-RUN is ignored
        @(negedge clk);
        b8.start = 1'b1; b8.sub = 1'b0; b8.a = 8'h12; b8.b = 8'h34; b8.cin = 1'b0;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        b8.start = 1'b1; b8.sub = 1'b1; b8.a = 8'hFF; b8.b = 8'hFF; b8.cin = 1'b1;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        n_done = 0;
        first_done = -1;
        sum_at_done = '0;
        for (int k = 5; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (b8.done) begin
                n_done++;
                if (n_done == 1) begin
                    first_done  = k;
                    sum_at_done = b8.sum;
                end
            end
        end
        check("ign_done_count", 64'(n_done), 64'd1);
        check("ign_latency", 64'(first_done), 64'd8);
        check("ign_sum", 64'(sum_at_done), 64'h46);
        check("ign_hold_sum", 64'(b8.sum), 64'h46);

        // reset in RUN cycle 4 aborts with no done
        @(negedge clk);
        b8.start = 1'b1; b8.sub = 1'b0; b8.a = 8'hFF; b8.b = 8'hFF; b8.cin = 1'b1;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(b8.busy), 64'd0);
        check("abort_done", 64'(b8.done), 64'd0);
        check("abort_sum",  64'(b8.sum),  64'd0);
        check("abort_cout", 64'(b8.cout), 64'd0);
        check("abort_ovf",  64'(b8.ovf),  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (b8.done || b8.busy) n_done++;
        end
        check("abort_no_activity", 64'(n_done), 64'd0);
        op8(1'b0, 8'h10, 8'h20, 1'b0, lat);
        check("post_rst_latency", 64'(lat), 64'd8);
        check("post_rst_sum",  64'(b8.sum),  64'h30);
        check("post_rst_cout", 64'(b8.cout), 64'd0);

        // WIDTH=1: full-adder truth table, start raised in the cycle after each done.
        // One RUN cycle plus DONE plus the IDLE sampling cycle gives a period of 3.
        last_done = 0;
        @(negedge clk);
        b1.start = 1'b1; b1.a = 1'b0; b1.b = 1'b0; b1.cin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wa = i[2];
            wb = i[1];
            wc = i[0];
            b1.a = wa;
            b1.b = wb;
            b1.cin = wc;
            b1.start = 1'b1;
            @(posedge clk);
            #1;
            b1.start = 1'b0;
            check($sformatf("w1_%0d_busy", i), 64'(b1.busy), 64'd1);
            lat = 0;
            while (!b1.done && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            exp2 = 2'(wa) + 2'(wb) + 2'(wc);
            check($sformatf("w1_%0d_latency", i), 64'(lat), 64'd1);
            check($sformatf("w1_%0d_result", i), 64'({b1.cout, b1.sum}), 64'(exp2));
            if (i > 0) check($sformatf("w1_%0d_period", i), 64'(cyc - last_done), 64'd3);
            last_done = cyc;
            @(posedge clk);
            #1;
            check($sformatf("w1_%0d_idle", i), 64'(b1.busy), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
